// File: rtl/mem_writeback_stage.sv
// Memory/writeback stage: registers ALU/PC results for the register file and runs
// a req/ack data-memory transaction (with timeout) for loads and stores.
module mem_writeback_stage #(
   parameter int DBITS          = 32,
   parameter int IDX_BITS       = 4,
   parameter int TIMEOUT_CYCLES = 16,
   parameter logic [1:0] SEL_ALU = 2'b00,
   parameter logic [1:0] SEL_MEM = 2'b01,
   parameter logic [1:0] SEL_PC  = 2'b10
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [IDX_BITS-1:0] inWrtIndex,
   input  logic                inRegWrEn,
   input  logic [1:0]          inMulSel,
   input  logic [DBITS-1:0]    inAluOut,
   input  logic [DBITS-1:0]    inData2Out,
   input  logic [DBITS-1:0]    inPC,
   input  logic                inIsLoad,
   input  logic                inIsStore,
   output logic                memStall,
   output logic [DBITS-1:0]    memAddr,
   output logic [DBITS-1:0]    memWrData,
   output logic                memRd,
   output logic                memWr,
   input  logic [DBITS-1:0]    memRdData,
   input  logic                memAck,
   output logic                wbWrEn,
   output logic [IDX_BITS-1:0] wbIndex,
   output logic [DBITS-1:0]    wbData,
   output logic                busErr
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

   typedef enum logic {IDLE, WAIT} state_t;

   typedef struct packed {
      logic [IDX_BITS-1:0] idx;
      logic                wr_en;
      logic                is_load;
   } pend_t;

   state_t          state;
   pend_t           pend;
   logic [CW-1:0]   cnt;
   logic            mem_op;
   logic            timeout_hit;
   logic [DBITS-1:0] sel_data;

   assign mem_op      = inIsLoad | inIsStore;
   assign timeout_hit = (cnt == CW'(TIMEOUT_CYCLES - 1));

   // Stall is combinational so the upstream register freezes in the issue cycle
   // and releases in the same cycle the ack (or timeout) arrives.
   always_comb begin
      memStall = 1'b0;
      if (!reset) begin
         case (state)
            IDLE:    memStall = mem_op;
            WAIT:    memStall = !memAck && !timeout_hit;
            default: memStall = 1'b0;
         endcase
      end
   end

   always_comb begin
      sel_data = '0;
      if (inMulSel == SEL_ALU)     sel_data = inAluOut;
      else if (inMulSel == SEL_PC) sel_data = inPC;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         pend      <= '0;
         cnt       <= '0;
         memAddr   <= '0;
         memWrData <= '0;
         memRd     <= 1'b0;
         memWr     <= 1'b0;
         wbWrEn    <= 1'b0;
         wbIndex   <= '0;
         wbData    <= '0;
         busErr    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (mem_op) begin
                  memAddr      <= inAluOut;
                  memWrData    <= inData2Out;
                  memWr        <= inIsStore;
                  memRd        <= !inIsStore;   // store wins when both flags are set
                  pend.idx     <= inWrtIndex;
                  pend.wr_en   <= inRegWrEn;
                  pend.is_load <= !inIsStore;
                  wbWrEn       <= 1'b0;
                  cnt          <= '0;
                  state        <= WAIT;
               end else begin
                  wbWrEn  <= inRegWrEn;
                  wbIndex <= inWrtIndex;
                  wbData  <= sel_data;
               end
            end
            WAIT: begin
               if (memAck) begin
                  memRd <= 1'b0;
                  memWr <= 1'b0;
                  state <= IDLE;
                  if (pend.is_load) begin
                     wbWrEn  <= pend.wr_en;
                     wbIndex <= pend.idx;
                     wbData  <= memRdData;
                  end else begin
                     wbWrEn <= 1'b0;
                  end
               end else if (timeout_hit) begin
                  memRd  <= 1'b0;
                  memWr  <= 1'b0;
                  busErr <= 1'b1;
                  wbWrEn <= 1'b0;
                  state  <= IDLE;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_writeback_stage.sv
// Scoreboard bench: the driver pushes expected register-file writes, a negedge
// monitor pops and compares them whenever wbWrEn pulses.
module tb_mem_writeback_stage;
   localparam int DB = 32;
   localparam int IW = 4;
   localparam int TO = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic [IW-1:0] inWrtIndex;
   logic          inRegWrEn;
   logic [1:0]    inMulSel;
   logic [DB-1:0] inAluOut, inData2Out, inPC;
   logic          inIsLoad, inIsStore;
   logic          memStall;
   logic [DB-1:0] memAddr, memWrData;
   logic          memRd, memWr;
   logic [DB-1:0] memRdData;
   logic          memAck;
   logic          wbWrEn;
   logic [IW-1:0] wbIndex;
   logic [DB-1:0] wbData;
   logic          busErr;

   mem_writeback_stage #(.DBITS(DB), .IDX_BITS(IW), .TIMEOUT_CYCLES(TO)) dut (
      .clk(clk), .reset(reset), .inWrtIndex(inWrtIndex), .inRegWrEn(inRegWrEn),
      .inMulSel(inMulSel), .inAluOut(inAluOut), .inData2Out(inData2Out), .inPC(inPC),
      .inIsLoad(inIsLoad), .inIsStore(inIsStore), .memStall(memStall), .memAddr(memAddr),
      .memWrData(memWrData), .memRd(memRd), .memWr(memWr), .memRdData(memRdData),
      .memAck(memAck), .wbWrEn(wbWrEn), .wbIndex(wbIndex), .wbData(wbData), .busErr(busErr)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [IW-1:0] idx;
      logic [DB-1:0] data;
   } wb_t;

   wb_t expq[$];
   int  checks = 0;
   int  errors = 0;
   bit  exp_busErr = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Monitor: every register-file write must match the oldest expected one.
   initial begin
      wb_t e;
      forever begin
         @(negedge clk);
         if (!reset && wbWrEn === 1'b1) begin
            if (expq.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL wb_unexpected actual idx=%0h data=%0h expected no write", wbIndex, wbData);
            end else begin
               e = expq.pop_front();
               chk("wb_index", wbIndex, e.idx);
               chk("wb_data", wbData, e.data);
            end
         end
      end
   end

   task automatic bubble();
      inWrtIndex = '0; inRegWrEn = 1'b0; inMulSel = 2'b00;
      inAluOut = '0; inData2Out = '0; inPC = '0;
      inIsLoad = 1'b0; inIsStore = 1'b0; memAck = 1'b0; memRdData = '0;
   endtask

   // Each op task starts just after a negedge and ends at the negedge after its last cycle.
   task automatic alu_op(input logic [IW-1:0] idx, input logic [1:0] sel, input logic [DB-1:0] alu,
                         input logic [DB-1:0] pc, input logic we, input logic stray_ack);
      logic [DB-1:0] d;
      inWrtIndex = idx; inRegWrEn = we; inMulSel = sel; inAluOut = alu; inPC = pc;
      inData2Out = $urandom; inIsLoad = 1'b0; inIsStore = 1'b0;
      memAck = stray_ack; memRdData = $urandom;
      #1 chk("alu_stall", memStall, 1'b0);
      d = (sel == 2'b00) ? alu : (sel == 2'b10) ? pc : '0;
      if (we) expq.push_back('{idx, d});
      @(negedge clk);
      memAck = 1'b0;
   endtask

   // ack_at = WAIT cycle (0-based) carrying the ack; ack_at >= TO means no ack.
   task automatic mem_op(input bit ld, input bit st, input logic [IW-1:0] idx, input logic we,
                         input logic [DB-1:0] addr, input logic [DB-1:0] wdata,
                         input int ack_at, input logic [DB-1:0] rdata);
      bit fin = 1'b0;
      inWrtIndex = idx; inRegWrEn = we; inMulSel = 2'b01; inAluOut = addr; inData2Out = wdata;
      inPC = $urandom; inIsLoad = ld; inIsStore = st; memAck = 1'b0;
      #1 chk("issue_stall", memStall, 1'b1);
      @(negedge clk);
      for (int w = 0; w < TO && !fin; w++) begin
         chk("mem_rd", memRd, !st);
         chk("mem_wr", memWr, st);
         chk("mem_addr", memAddr, addr);
         chk("mem_wrdata", memWrData, wdata);
         if (w == ack_at) begin
            memAck = 1'b1; memRdData = rdata;
            #1 chk("ack_stall", memStall, 1'b0);
            if (!st && we) expq.push_back('{idx, rdata});
            @(negedge clk);
            memAck = 1'b0; memRdData = $urandom;
            fin = 1'b1;
         end else if (w == TO - 1) begin
            #1 chk("timeout_stall", memStall, 1'b0);
            exp_busErr = 1'b1;
            @(negedge clk);
            fin = 1'b1;
         end else begin
            #1 chk("wait_stall", memStall, 1'b1);
            @(negedge clk);
         end
      end
      bubble();
      chk("req_dropped", {memRd, memWr}, 2'b00);
      chk("bus_err", busErr, exp_busErr);
   endtask

   initial begin
      int kind;
      bubble();
      reset = 1'b1;
      @(negedge clk);
      chk("rst_outputs", {memStall, memRd, memWr, wbWrEn, busErr}, 5'b0);
      chk("rst_data", {memAddr, memWrData, wbData}, 96'b0);
      chk("rst_index", wbIndex, 0);
      reset = 1'b0;
      @(negedge clk);

      // Directed cases
      alu_op(4'd3, 2'b00, 32'h55, 32'h0, 1'b1, 1'b0);
      alu_op(4'd7, 2'b10, 32'h1, 32'h8000_0004, 1'b1, 1'b0);
      alu_op(4'd9, 2'b01, 32'h77, 32'h0, 1'b1, 1'b0);
      alu_op(4'd2, 2'b11, 32'h78, 32'h9, 1'b1, 1'b0);
      mem_op(1, 0, 4'd5, 1'b1, 32'h100, 32'h0, 3, 32'hCAFE);   // ack on the timeout cycle
      mem_op(0, 1, 4'd6, 1'b1, 32'h40, 32'h1234, 0, 32'hDEAD);
      mem_op(1, 1, 4'd8, 1'b1, 32'h44, 32'h5678, 1, 32'hBEEF);  // both flags: store
      mem_op(1, 0, 4'd4, 1'b1, 32'h200, 32'h0, TO, 32'h0);     // no ack: timeout
      alu_op(4'd1, 2'b00, 32'hA5A5, 32'h0, 1'b1, 1'b1);        // stray ack ignored
      chk("bus_err_sticky", busErr, 1'b1);

      // Reset in the middle of a WAIT
      inWrtIndex = 4'd12; inRegWrEn = 1'b1; inAluOut = 32'h300; inIsLoad = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #1 reset = 1'b1;
      #1 chk("rst_mid_req", {memRd, memWr}, 2'b00);
      chk("rst_mid_stall", memStall, 1'b0);
      chk("rst_mid_wb", wbWrEn, 1'b0);
      chk("rst_mid_buserr", busErr, 1'b0);
      exp_busErr = 1'b0;
      @(negedge clk);
      bubble();
      reset = 1'b0;
      @(negedge clk);
      mem_op(1, 0, 4'd13, 1'b1, 32'h304, 32'h0, 1, 32'h1357_9BDF);

      // Randomized traffic
      for (int i = 0; i < 120; i++) begin
         kind = $urandom_range(0, 4);
         if (kind < 2)
            alu_op(IW'($urandom), 2'($urandom), $urandom, $urandom, 1'($urandom), 1'($urandom_range(0, 3) == 0));
         else
            mem_op(kind != 3, kind != 2, IW'($urandom), 1'($urandom), $urandom, $urandom,
                   $urandom_range(0, TO), $urandom);
      end

      bubble();
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", expq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
